// File: rtl/fp_accumulator.sv
// Streaming single-precision accumulator driving an external stb/ack adder.
// Optional FP_ACC_BYPASS_FIRST_EN loads the first element of each group directly into the running sum.
module fp_accumulator #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            in_data,
  input  logic                   in_last,
  input  logic                   in_stb,
  output logic                   in_ack,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  output logic                   add_a_stb,
  output logic                   add_b_stb,
  input  logic                   add_a_ack,
  input  logic                   add_b_ack,
  input  logic [31:0]            add_z,
  input  logic                   add_z_stb,
  output logic                   add_z_ack,
  output logic [31:0]            sum_z,
  output logic [COUNT_WIDTH-1:0] sum_count,
  output logic                   sum_stb,
  input  logic                   sum_ack
);

  typedef enum logic [2:0] {
    GET_X   = 3'd0,
    SEND_A  = 3'd1,
    SEND_B  = 3'd2,
    GET_Z   = 3'd3,
    PUT_SUM = 3'd4
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_r, state_s;
  logic [31:0]            acc_r, acc_s;
  logic [31:0]            x_r, x_s;
  logic                   last_r, last_s;
  logic [COUNT_WIDTH-1:0] cnt_r, cnt_s;
`ifdef FP_ACC_BYPASS_FIRST_EN
  logic                   first_r, first_s;
`endif
  logic                   in_ack_r, in_ack_s;
  logic [31:0]            add_a_r, add_a_s;
  logic [31:0]            add_b_r, add_b_s;
  logic                   add_a_stb_r, add_a_stb_s;
  logic                   add_b_stb_r, add_b_stb_s;
  logic                   add_z_ack_r, add_z_ack_s;
  logic [31:0]            sum_z_r, sum_z_s;
  logic [COUNT_WIDTH-1:0] sum_count_r, sum_count_s;
  logic                   sum_stb_r, sum_stb_s;

  assign in_ack    = in_ack_r;
  assign add_a     = add_a_r;
  assign add_b     = add_b_r;
  assign add_a_stb = add_a_stb_r;
  assign add_b_stb = add_b_stb_r;
  assign add_z_ack = add_z_ack_r;
  assign sum_z     = sum_z_r;
  assign sum_count = sum_count_r;
  assign sum_stb   = sum_stb_r;

  // Next-state and next-register values; every register holds unless its state touches it.
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    x_s         = x_r;
    last_s      = last_r;
    cnt_s       = cnt_r;
`ifdef FP_ACC_BYPASS_FIRST_EN
    first_s     = first_r;
`endif
    in_ack_s    = in_ack_r;
    add_a_s     = add_a_r;
    add_b_s     = add_b_r;
    add_a_stb_s = add_a_stb_r;
    add_b_stb_s = add_b_stb_r;
    add_z_ack_s = add_z_ack_r;
    sum_z_s     = sum_z_r;
    sum_count_s = sum_count_r;
    sum_stb_s   = sum_stb_r;

    case (state_r)
      GET_X: begin
        if (in_ack_r && in_stb) begin
          x_s      = in_data;
          last_s   = in_last;
          in_ack_s = 1'b0;
          cnt_s    = cnt_r + CNT_ONE;
`ifdef FP_ACC_BYPASS_FIRST_EN
          // The first element needs no add: acc is still +0.0 and we keep its exact bits.
          if (first_r) begin
            acc_s   = in_data;
            first_s = 1'b0;
            state_s = in_last ? PUT_SUM : GET_X;
          end else begin
            state_s = SEND_A;
          end
`else
          state_s  = SEND_A;
`endif
        end else begin
          in_ack_s = 1'b1;
        end
      end

      SEND_A: begin
        add_a_s = acc_r;
        if (add_a_stb_r && add_a_ack) begin
          add_a_stb_s = 1'b0;
          state_s     = SEND_B;
        end else begin
          add_a_stb_s = 1'b1;
        end
      end

      SEND_B: begin
        add_b_s = x_r;
        if (add_b_stb_r && add_b_ack) begin
          add_b_stb_s = 1'b0;
          state_s     = GET_Z;
        end else begin
          add_b_stb_s = 1'b1;
        end
      end

      GET_Z: begin
        if (add_z_ack_r && add_z_stb) begin
          acc_s       = add_z;
          add_z_ack_s = 1'b0;
          state_s     = last_r ? PUT_SUM : GET_X;
        end else begin
          add_z_ack_s = 1'b1;
        end
      end

      PUT_SUM: begin
        sum_z_s     = acc_r;
        sum_count_s = cnt_r;
        if (sum_stb_r && sum_ack) begin
          sum_stb_s = 1'b0;
          acc_s     = 32'h0000_0000;
          cnt_s     = CNT_ZERO;
`ifdef FP_ACC_BYPASS_FIRST_EN
          first_s   = 1'b1;
`endif
          state_s   = GET_X;
        end else begin
          sum_stb_s = 1'b1;
        end
      end

      default: begin
        in_ack_s    = 1'b0;
        add_a_stb_s = 1'b0;
        add_b_stb_s = 1'b0;
        add_z_ack_s = 1'b0;
        sum_stb_s   = 1'b0;
        state_s     = GET_X;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= GET_X;
      acc_r       <= 32'h0000_0000;
      x_r         <= 32'h0000_0000;
      last_r      <= 1'b0;
      cnt_r       <= CNT_ZERO;
`ifdef FP_ACC_BYPASS_FIRST_EN
      first_r     <= 1'b1;
`endif
      in_ack_r    <= 1'b0;
      add_a_r     <= 32'h0000_0000;
      add_b_r     <= 32'h0000_0000;
      add_a_stb_r <= 1'b0;
      add_b_stb_r <= 1'b0;
      add_z_ack_r <= 1'b0;
      sum_z_r     <= 32'h0000_0000;
      sum_count_r <= CNT_ZERO;
      sum_stb_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      x_r         <= x_s;
      last_r      <= last_s;
      cnt_r       <= cnt_s;
`ifdef FP_ACC_BYPASS_FIRST_EN
      first_r     <= first_s;
`endif
      in_ack_r    <= in_ack_s;
      add_a_r     <= add_a_s;
      add_b_r     <= add_b_s;
      add_a_stb_r <= add_a_stb_s;
      add_b_stb_r <= add_b_stb_s;
      add_z_ack_r <= add_z_ack_s;
      sum_z_r     <= sum_z_s;
      sum_count_r <= sum_count_s;
      sum_stb_r   <= sum_stb_s;
    end
  end

  fp_accumulator_checker #(.COUNT_WIDTH(COUNT_WIDTH)) u_checker (
    .clk       (clk),
    .rst       (rst),
    .add_a     (add_a_r),
    .add_a_stb (add_a_stb_r),
    .add_a_ack (add_a_ack),
    .add_b     (add_b_r),
    .add_b_stb (add_b_stb_r),
    .add_b_ack (add_b_ack),
    .sum_z     (sum_z_r),
    .sum_count (sum_count_r),
    .sum_stb   (sum_stb_r),
    .sum_ack   (sum_ack)
  );

endmodule

// Handshake protocol properties for the initiator-side links.
module fp_accumulator_checker #(
  parameter int COUNT_WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst,
  input logic [31:0]            add_a,
  input logic                   add_a_stb,
  input logic                   add_a_ack,
  input logic [31:0]            add_b,
  input logic                   add_b_stb,
  input logic                   add_b_ack,
  input logic [31:0]            sum_z,
  input logic [COUNT_WIDTH-1:0] sum_count,
  input logic                   sum_stb,
  input logic                   sum_ack
);

  a_add_a_hold: assert property (@(posedge clk) disable iff (rst)
    (add_a_stb && !add_a_ack) |=> (add_a_stb && $stable(add_a)));
  a_add_b_hold: assert property (@(posedge clk) disable iff (rst)
    (add_b_stb && !add_b_ack) |=> (add_b_stb && $stable(add_b)));
  a_sum_hold: assert property (@(posedge clk) disable iff (rst)
    (sum_stb && !sum_ack) |=> (sum_stb && $stable(sum_z) && $stable(sum_count)));

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator with a behavioural adder peer and a sum scoreboard.
module tb_fp_accumulator;
  localparam int CW = 2;
`ifdef FP_ACC_BYPASS_FIRST_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [31:0]   in_data = 32'h0;
  logic          in_last = 1'b0;
  logic          in_stb = 1'b0;
  logic          in_ack;
  logic [31:0]   add_a, add_b;
  logic          add_a_stb, add_b_stb;
  logic          add_a_ack = 1'b0;
  logic          add_b_ack = 1'b0;
  logic [31:0]   add_z = 32'h0;
  logic          add_z_stb = 1'b0;
  logic          add_z_ack;
  logic [31:0]   sum_z;
  logic [CW-1:0] sum_count;
  logic          sum_stb;
  logic          sum_ack = 1'b0;

  fp_accumulator #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_last(in_last), .in_stb(in_stb), .in_ack(in_ack),
    .add_a(add_a), .add_b(add_b), .add_a_stb(add_a_stb), .add_b_stb(add_b_stb),
    .add_a_ack(add_a_ack), .add_b_ack(add_b_ack),
    .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
    .sum_z(sum_z), .sum_count(sum_count), .sum_stb(sum_stb), .sum_ack(sum_ack)
  );

  typedef struct { logic [31:0] z; logic [CW-1:0] n; } exp_t;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic sink_hold = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference adder for normals and zeros; any NaN operand yields the canonical ffc00000.
  function automatic real sp2r(input logic [31:0] w);
    real m;
    int  e;
    if (w[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(w[22:0]) / 8388608.0;
    e = int'(w[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return w[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic s;
    int   e;
    int   f;
    if (r == 0.0) return 32'h0000_0000;
    s = (r < 0.0);
    if (s) r = -r;
    e = 127;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0) begin r = r * 2.0; e--; end
    f = $rtoi((r - 1.0) * 8388608.0);
    return {s, e[7:0], f[22:0]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if ((a[30:23] == 8'hff && a[22:0] != 23'd0) || (b[30:23] == 8'hff && b[22:0] != 23'd0))
      return 32'hffc0_0000;
    return r2sp(sp2r(a) + sp2r(b));
  endfunction

  int          pst = 0;
  logic [31:0] op_a, op_b;

  // Adder peer: accept A, accept B, present Z; restarts on rst like the real unit.
  always @(negedge clk) begin
    if (rst) begin
      pst = 0; add_a_ack = 1'b0; add_b_ack = 1'b0; add_z_stb = 1'b0;
    end else begin
      case (pst)
        0: if (add_a_stb) begin op_a = add_a; add_a_ack = 1'b1; pst = 1; end
        1: begin add_a_ack = 1'b0; pst = 2; end
        2: if (add_b_stb) begin op_b = add_b; add_b_ack = 1'b1; pst = 3; end
        3: begin add_b_ack = 1'b0; add_z = fadd(op_a, op_b); add_z_stb = 1'b1; pst = 4; end
        4: if (add_z_ack) pst = 5;
        5: begin add_z_stb = 1'b0; pst = 0; end
        default: pst = 0;
      endcase
    end
  end

  // Sum sink: compares each delivered sum against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst) sum_ack = 1'b0;
    else if (sum_ack) sum_ack = 1'b0;
    else if (sum_stb && !sink_hold) begin
      chk("sum_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sum_z", sum_z, e.z);
        chk("sum_count", 32'(sum_count), 32'(e.n));
      end
      sum_ack = 1'b1;
    end
  end

  task automatic push(input logic [31:0] z, input int n);
    exp_t e;
    e.z = z;
    e.n = n[CW-1:0];
    sb.push_back(e);
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    in_data = d; in_last = l; in_stb = 1'b1;
    while (!in_ack && n < 300) begin @(negedge clk); n++; end
    chk("in_ack_seen", {31'd0, in_ack}, 32'd1);
    @(negedge clk);
    in_stb = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || sum_stb) && n < 500) begin @(negedge clk); n++; end
    chk("drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] held;
    int n;
    repeat (2) @(negedge clk);
    chk("rst_in_ack", {31'd0, in_ack}, 32'd0);
    chk("rst_add_a_stb", {31'd0, add_a_stb}, 32'd0);
    chk("rst_add_b_stb", {31'd0, add_b_stb}, 32'd0);
    chk("rst_add_z_ack", {31'd0, add_z_ack}, 32'd0);
    chk("rst_sum_stb", {31'd0, sum_stb}, 32'd0);
    chk("rst_sum_z", sum_z, 32'd0);
    chk("rst_sum_count", 32'(sum_count), 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_add_b", add_b, 32'd0);
    rst = 1'b0;

    // 1 + 2 + 3
    push(32'h40c0_0000, 3);
    send(32'h3f80_0000, 1'b0);
    send(32'h4000_0000, 1'b0);
    send(32'h4040_0000, 1'b1);
    drain();

    // single -0.0
    push(BYP ? 32'h8000_0000 : 32'h0000_0000, 1);
    send(32'h8000_0000, 1'b1);
    drain();

    // NaN propagation
    push(32'hffc0_0000, 2);
    send(32'h7fc0_0001, 1'b0);
    send(32'h3f80_0000, 1'b1);
    drain();
    push(BYP ? 32'h7fc0_0001 : 32'hffc0_0000, 1);
    send(32'h7fc0_0001, 1'b1);
    drain();

    // downstream back-pressure for 20 cycles
    sink_hold = 1'b1;
    push(32'h4040_0000, 2);
    send(32'h3f80_0000, 1'b0);
    send(32'h4000_0000, 1'b1);
    n = 0;
    while (!sum_stb && n < 300) begin @(negedge clk); n++; end
    chk("hold_sum_stb_seen", {31'd0, sum_stb}, 32'd1);
    held = sum_z;
    repeat (20) begin
      @(negedge clk);
      chk("hold_sum_stb", {31'd0, sum_stb}, 32'd1);
      chk("hold_sum_z", sum_z, held);
      chk("hold_in_ack", {31'd0, in_ack}, 32'd0);
    end
    #1 sink_hold = 1'b0;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!sum_ack && n < 20);
    chk("release_ack_seen", {31'd0, sum_ack}, 32'd1);
    @(negedge clk);
    chk("release_sum_stb", {31'd0, sum_stb}, 32'd0);
    chk("release_in_ack_lo", {31'd0, in_ack}, 32'd0);
    @(negedge clk);
    chk("release_in_ack_hi", {31'd0, in_ack}, 32'd1);
    drain();

    // count wraps modulo 4
    push(32'h40a0_0000, 1);
    repeat (4) send(32'h3f80_0000, 1'b0);
    send(32'h3f80_0000, 1'b1);
    drain();

    // reset while operand B is offered
    send(32'h3f80_0000, 1'b0);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!add_b_stb && n < 300);
    chk("add_b_stb_seen", {31'd0, add_b_stb}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ack", {31'd0, in_ack}, 32'd0);
    chk("mid_rst_add_a_stb", {31'd0, add_a_stb}, 32'd0);
    chk("mid_rst_add_b_stb", {31'd0, add_b_stb}, 32'd0);
    chk("mid_rst_add_z_ack", {31'd0, add_z_ack}, 32'd0);
    chk("mid_rst_sum_stb", {31'd0, sum_stb}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ack", {31'd0, in_ack}, 32'd1);
    push(32'h4000_0000, 1);
    send(32'h4000_0000, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
